// File: rtl/fir_pkg.sv
// Shared constants, FSM encodings and the output rounding/saturation helper
// for the folded symmetric FIR engine.
package fir_pkg;

  localparam int NTAPS     = 64;
  localparam int HALF_TAPS = NTAPS / 2;
  localparam int DATA_W    = 16;
  localparam int COEF_W    = 16;
  localparam int ACC_W     = 38;
  localparam int ADDR_W    = $clog2(NTAPS);
  localparam int K_W       = $clog2(HALF_TAPS);

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_MAC  = 2'd1;
  localparam state_t ST_OUT  = 2'd2;

  localparam logic signed [ACC_W-1:0] ROUND_HALF = ACC_W'(1) <<< (DATA_W - 2);
  localparam logic signed [ACC_W-1:0] SAT_HI     = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] SAT_LO     = -ACC_W'(32768);

  // Round-half-up back to Q1.15 and clamp to the 16-bit signed range.
  function automatic logic signed [DATA_W-1:0] round_sat(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] r;
    r = (acc + ROUND_HALF) >>> (DATA_W - 1);
    if (r > SAT_HI)
      return DATA_W'(SAT_HI);
    else if (r < SAT_LO)
      return DATA_W'(SAT_LO);
    else
      return DATA_W'(r);
  endfunction

endpackage

// File: rtl/fir_delay_line.sv
// 64-entry circular sample store with one write port and two combinational
// read ports (newest-side and oldest-side taps of each folded pair).
module fir_delay_line
  import fir_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        wr_ptr,
  input  logic signed [DATA_W-1:0] din,
  input  logic [ADDR_W-1:0]        addr_a,
  input  logic [ADDR_W-1:0]        addr_b,
  output logic signed [DATA_W-1:0] dout_a,
  output logic signed [DATA_W-1:0] dout_b
);

  logic signed [DATA_W-1:0] mem [NTAPS];

  // Clearing on reset makes the first outputs see zero history.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NTAPS; i++) mem[i] <= '0;
    end else if (we) begin
      mem[wr_ptr] <= din;
    end
  end

  assign dout_a = mem[addr_a];
  assign dout_b = mem[addr_b];

endmodule

// File: rtl/fir_sym_mac.sv
// Time-multiplexed 64-tap symmetric FIR: one accepted sample, 32 folded
// MAC cycles against the external coefficient ROM, one held result.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | in_ready high; accept stores sample, latches tone, clears acc
// MAC     | k = 0..31, acc += (x[base-k] + x[base-63+k]) * coef[k]
// OUT     | first cycle rounds/saturates acc; then hold until out_ready
module fir_sym_mac
  import fir_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     tone_sel,
  output logic [ADDR_W-1:0]        coef_addr,
  output logic                     coef_tone,
  input  logic signed [COEF_W-1:0] coef_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_data
);

  state_t                   state;
  logic [ADDR_W-1:0]        wr_ptr;
  logic [ADDR_W-1:0]        base;
  logic [K_W-1:0]           k;
  logic signed [ACC_W-1:0]  acc;

  logic                     accept;
  logic [ADDR_W-1:0]        addr_a;
  logic [ADDR_W-1:0]        addr_b;
  logic signed [DATA_W-1:0] tap_a;
  logic signed [DATA_W-1:0] tap_b;
  logic signed [DATA_W:0]   pre;
  logic signed [DATA_W+COEF_W:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;

  assign in_ready = (state == ST_IDLE);
  assign accept   = in_valid && in_ready;

  // base-63+k is base+1+k modulo 64; the 6-bit pointers wrap for free.
  assign addr_a = base - {1'b0, k};
  assign addr_b = base + ADDR_W'(1) + {1'b0, k};

  assign coef_addr = (state == ST_MAC) ? {1'b0, k} : '0;

  fir_delay_line u_delay (
    .clk    (clk),
    .rst    (rst),
    .we     (accept),
    .wr_ptr (wr_ptr),
    .din    (in_data),
    .addr_a (addr_a),
    .addr_b (addr_b),
    .dout_a (tap_a),
    .dout_b (tap_b)
  );

  assign pre      = {tap_a[DATA_W-1], tap_a} + {tap_b[DATA_W-1], tap_b};
  assign prod     = pre * coef_data;
  assign prod_ext = ACC_W'(prod);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      wr_ptr    <= '0;
      base      <= '0;
      k         <= '0;
      acc       <= '0;
      coef_tone <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            base      <= wr_ptr;
            wr_ptr    <= wr_ptr + ADDR_W'(1);
            coef_tone <= tone_sel;
            acc       <= '0;
            k         <= '0;
            state     <= ST_MAC;
          end
        end
        ST_MAC: begin
          acc <= acc + prod_ext;
          k   <= k + K_W'(1);
          if (k == K_W'(HALF_TAPS - 1)) state <= ST_OUT;
        end
        ST_OUT: begin
          if (!out_valid) begin
            out_data  <= round_sat(acc);
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
